// File: rtl/pipe_stage_skid.sv
// Pipeline register stage with a one-entry skid buffer so up_ready can be registered.
// Define PIPE_STAGE_PERF_EN to build in the saturating stall/beat performance counters.
module pipe_stage_skid #(
  parameter int DATA_W = 103
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] up_data,
  output logic              up_ready,
  output logic              dn_valid,
  output logic [DATA_W-1:0] dn_data,
  input  logic              dn_ready,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_beat_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              up_ready_q, up_ready_d;
  logic              up_xfer, dn_xfer;

  assign dn_valid = (state_q != EMPTY);
  assign dn_data  = main_q;
  assign up_ready = up_ready_q;
  assign up_xfer  = up_valid & up_ready_q;
  assign dn_xfer  = dn_valid & dn_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Any beat offered alongside flush is swallowed along with the held ones.
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (up_xfer) begin
            state_d = FULL;
            main_d  = up_data;
          end
        end
        FULL: begin
          if (up_xfer && dn_xfer) begin
            main_d = up_data;
          end else if (up_xfer) begin
            state_d = SKID;
            skid_d  = up_data;
          end else if (dn_xfer) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          if (dn_xfer) begin
            state_d = FULL;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // Ready is a flop: it already reflects whether next cycle has room.
    up_ready_d = (state_d != SKID);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      up_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      up_ready_q <= up_ready_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    if (dn_valid && !dn_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    // A flushed cycle completes no transfer.
    if (dn_xfer && !flush && (beat_cnt_q != 32'hFFFF_FFFF)) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      beat_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_beat_cnt  = beat_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_beat_cnt  = '0;
`endif

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 103, payload width (wd 5 + wreg 1 + wdata 32 + hi 32 + lo 32 + whilo 1).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  synchronous discard of all held beats.
REQ-005 SHALL have port up_valid  input  1  upstream beat present.
REQ-006 SHALL have port up_data  input  DATA_W  upstream payload.
REQ-007 SHALL have port up_ready  output  1  stage can accept a beat; a registered output.
REQ-008 SHALL have port dn_valid  output  1  downstream beat present.
REQ-009 SHALL have port dn_data  output  DATA_W  downstream payload.
REQ-010 SHALL have port dn_ready  input  1  downstream accepts a beat.
REQ-011 SHALL have port perf_stall_cnt  output  32  cycles with dn_valid=1 and dn_ready=0.
REQ-012 SHALL have port perf_beat_cnt  output  32  completed downstream transfers.

Function
REQ-013 SHALL define an upstream transfer as up_valid&up_ready and a downstream transfer as dn_valid&dn_ready, each sampled at the clk edge.
REQ-014 SHALL hold state EMPTY (no beat), FULL (main register valid) or SKID (main and skid registers valid); dn_valid=1 in FULL and SKID; up_ready=0 only in SKID.
REQ-015 SHALL transition EMPTY -> FULL on an upstream transfer, with main<=up_data.
REQ-016 SHALL, in FULL, stay FULL with main<=up_data on simultaneous upstream and downstream transfers; go to SKID with skid<=up_data on an upstream transfer only; go to EMPTY on a downstream transfer only.
REQ-017 SHALL transition SKID -> FULL with main<=skid on a downstream transfer, and otherwise hold SKID.
REQ-018 SHALL drive dn_data from the main register; latency up_data -> dn_data is 1 cycle; sustained throughput is 1 beat/cycle when dn_ready=1.
REQ-019 SHALL never drop, duplicate or reorder a beat; downstream order equals upstream acceptance order.
REQ-020 SHALL keep dn_data stable while dn_valid=1 and dn_ready=0.
REQ-021 SHALL, on flush=1, go to EMPTY next cycle, clear main and skid data to zero, and treat any upstream beat offered in that cycle as consumed and discarded; flush has priority over all transfers.
REQ-022 SHALL let dn_data hold its last value in EMPTY, apart from the zeroing caused by rst or flush.
REQ-023 SHALL increment perf_stall_cnt and perf_beat_cnt by 1 per qualifying cycle, saturating at 32'hFFFFFFFF; flush does not clear them.

Reset
REQ-024 SHALL, on rst=1 at a clk edge, set state EMPTY, up_ready=1, dn_valid=0, dn_data=0, skid data=0, perf_stall_cnt=0 and perf_beat_cnt=0.
REQ-025 SHALL give rst priority over flush and over all transfers; a reset mid-operation discards held beats with no downstream transfer in that cycle.

Configuration
REQ-026 SHALL use macro PIPE_STAGE_PERF_EN to compile the counters in or out.
REQ-027 SHALL, with PIPE_STAGE_PERF_EN defined, implement REQ-011, REQ-012 and REQ-023 as specified.
REQ-028 SHALL, without PIPE_STAGE_PERF_EN, keep both counter ports with constant 0 and no counter flops; all other behaviour is unchanged.

Verification
REQ-029 SHALL cover streaming: dn_ready=1, up_valid=1 with data 1,2,3,4 on consecutive cycles -> dn_data 1,2,3,4 one cycle later each, with no bubbles.
REQ-030 SHALL cover backpressure: dn_ready=0 while beats A=0x11 and B=0x22 are sent -> state SKID, up_ready=0, dn_data=0x11 held; then dn_ready=1 -> 0x11 then 0x22 out, up_ready=1 again.
REQ-031 SHALL cover flush in SKID with up_valid=1 -> next cycle dn_valid=0, dn_data=0, and no further beats emerge.
REQ-032 SHALL cover reset mid-stream: rst=1 for 1 cycle while in FULL -> dn_valid=0, up_ready=1, counters=0 next cycle.
REQ-033 SHALL cover counters (macro on): 5 stalled cycles then 3 transfers -> perf_stall_cnt=5, perf_beat_cnt=3; counter preloaded to 0xFFFFFFFF stays 0xFFFFFFFF; with the macro off both read 0.
REQ-034 SHALL cover simultaneous events in FULL: upstream and downstream transfers in the same cycle -> stays FULL and the new beat appears next cycle.
